// File: rtl/lcd_pkg.sv
// Shared opcodes, command-bus field positions and sequencer state encoding
// for the HD44780 command source.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

  localparam int COMM_RW  = 8;
  localparam int COMM_RS  = 9;
  localparam int COMM_SEL = 10;
  localparam int COMM_W   = 11;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_INIT,
    ST_ADDR,
    ST_CHAR,
    ST_IDLE
  } state_e;

  function automatic logic [7:0] init_opcode(input logic [1:0] step);
    logic [7:0] op;
    case (step)
      2'd0:    op = LCD_FUNC_SET;
      2'd1:    op = LCD_DISP_ON;
      2'd2:    op = LCD_CLEAR;
      default: op = LCD_ENTRY;
    endcase
    return op;
  endfunction

  // Instruction path: display sees source select low and routes the opcode.
  function automatic logic [COMM_W-1:0] instr_cmd(input logic [7:0] op);
    logic [COMM_W-1:0] c;
    c           = '0;
    c[7:0]      = op;
    c[COMM_RW]  = 1'b0;
    c[COMM_RS]  = 1'b0;
    c[COMM_SEL] = 1'b0;
    return c;
  endfunction

  function automatic logic [COMM_W-1:0] char_cmd(input logic [7:0] n);
    logic [COMM_W-1:0] c;
    c           = '0;
    c[7:0]      = n;
    c[COMM_RW]  = 1'b0;
    c[COMM_RS]  = 1'b1;
    c[COMM_SEL] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Up-counter shared by every wait in the sequencer; o_done flags the last
// cycle of a LIMIT-cycle interval, and i_clr restarts it from zero.
module lcd_delay_timer #(
  parameter int TW = 19
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic [TW-1:0] i_limit,
  output logic          o_done
);

  localparam logic [TW-1:0] ONE = TW'(1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + ONE;
    if (i_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == (i_limit - ONE));

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 command source: power-up wait, 4-instruction init, then on request
// a set-DDRAM-address followed by one data write per character-bank byte.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int SIZE     = 4,
  parameter int STEP_CYC = 1250,
  parameter int PWR_CYC  = 375000,
  parameter int CLR_CYC  = 41000,
  parameter int TW       = 19
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_update,
  input  logic [SIZE*8-1:0] i_data,
  input  logic [6:0]        i_col,
  output logic [10:0]       o_comm,
  output logic [SIZE*8-1:0] o_data,
  output logic              o_strobe,
  output logic              o_busy,
  output logic              o_ready
);

  localparam logic [7:0] LAST_CHAR = 8'(SIZE - 2);

  state_e              state_q,   state_d;
  logic [1:0]          step_q,    step_d;
  logic [7:0]          n_q,       n_d;
  logic [COMM_W-1:0]   comm_q,    comm_d;
  logic [SIZE*8-1:0]   data_q,    data_d;
  logic                strobe_q,  strobe_d;
  logic                busy_q,    busy_d;
  logic                ready_q,   ready_d;
  logic                pending_q, pending_d;

  logic          t_clr;
  logic          t_done;
  logic [TW-1:0] t_limit;

  always_comb begin
    t_limit = TW'(STEP_CYC);
    if (state_q == ST_PWR) begin
      t_limit = TW'(PWR_CYC);
    end else if (state_q == ST_INIT && step_q == 2'd2) begin
      t_limit = TW'(CLR_CYC);
    end
  end

  // Every busy state advances exactly when its wait expires, so the expiry
  // itself restarts the timer; IDLE keeps it parked at zero.
  assign t_clr = t_done || (state_q == ST_IDLE);

  lcd_delay_timer #(
    .TW(TW)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (t_clr),
    .i_limit (t_limit),
    .o_done  (t_done)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    n_d       = n_q;
    comm_d    = comm_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    ready_d   = ready_q;
    // A request while busy is folded into a single pending refresh.
    pending_d = pending_q || (i_update && state_q != ST_IDLE);

    case (state_q)
      ST_PWR: begin
        if (t_done) begin
          state_d  = ST_INIT;
          step_d   = 2'd0;
          comm_d   = instr_cmd(init_opcode(2'd0));
          strobe_d = 1'b1;
        end
      end

      ST_INIT: begin
        if (t_done) begin
          if (step_q == 2'd3) begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
          end else begin
            step_d   = step_q + 2'd1;
            comm_d   = instr_cmd(init_opcode(step_q + 2'd1));
            strobe_d = 1'b1;
          end
        end
      end

      ST_IDLE: begin
        if (i_update || pending_q) begin
          state_d   = ST_ADDR;
          data_d    = i_data;
          pending_d = 1'b0;
          comm_d    = instr_cmd(LCD_SET_DDRAM | {1'b0, i_col});
          strobe_d  = 1'b1;
        end
      end

      ST_ADDR: begin
        if (t_done) begin
          state_d  = ST_CHAR;
          n_d      = 8'd0;
          comm_d   = char_cmd(8'd0);
          strobe_d = 1'b1;
        end
      end

      ST_CHAR: begin
        if (t_done) begin
          if (n_q == LAST_CHAR) begin
            state_d = ST_IDLE;
          end else begin
            n_d      = n_q + 8'd1;
            comm_d   = char_cmd(n_q + 8'd1);
            strobe_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_PWR;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_PWR;
      step_q    <= 2'd0;
      n_q       <= 8'd0;
      comm_q    <= '0;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b1;
      ready_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      n_q       <= n_d;
      comm_q    <= comm_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      pending_q <= pending_d;
    end
  end

  assign o_comm   = comm_q;
  assign o_data   = data_q;
  assign o_strobe = strobe_q;
  assign o_busy   = busy_q;
  assign o_ready  = ready_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboard bench for lcd_sequencer: every strobe pops one expected command,
// snapshot and spacing (cycles since the previous strobe or reference point).
module tb_lcd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        update;
  logic [31:0] data;
  logic [6:0]  col;
  logic [10:0] comm;
  logic [31:0] odata;
  logic        strobe;
  logic        busy;
  logic        ready;

  int tests;
  int fails;
  int cyc;
  int last_cyc;

  typedef struct packed {
    logic [10:0] comm;
    logic [31:0] data;
    logic [31:0] gap;
  } exp_t;

  exp_t sb[$];

  lcd_sequencer #(
    .SIZE     (4),
    .STEP_CYC (4),
    .PWR_CYC  (20),
    .CLR_CYC  (10),
    .TW       (19)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_update (update),
    .i_data   (data),
    .i_col    (col),
    .o_comm   (comm),
    .o_data   (odata),
    .o_strobe (strobe),
    .o_busy   (busy),
    .o_ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [10:0] c, input logic [31:0] d, input int gap);
    exp_t e;
    e.comm = c;
    e.data = d;
    e.gap  = 32'(gap);
    sb.push_back(e);
  endtask

  task automatic push_init(input int first_gap);
    push(11'h038, 32'd0, first_gap);
    push(11'h00C, 32'd0, 4);
    push(11'h001, 32'd0, 4);
    push(11'h006, 32'd0, 10);
  endtask

  task automatic push_frame(input logic [31:0] d, input logic [6:0] c, input int first_gap);
    push({3'b000, 8'h80 | {1'b0, c}}, d, first_gap);
    for (int k = 0; k < 3; k++) begin
      push({3'b110, 8'(k)}, d, 4);
    end
  endtask

  task automatic pulse_update(input bit set_ref);
    @(negedge clk);
    #1 update = 1'b1;
    if (set_ref) last_cyc = cyc;
    @(negedge clk);
    #1 update = 1'b0;
  endtask

  task automatic wait_size(input int sz, input int budget, input string tag);
    int k;
    k = 0;
    while (sb.size() > sz && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_eq(tag, 64'(sb.size()), 64'(sz));
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_comm"},   64'(comm),   64'd0);
    check_eq({tag, "_data"},   64'(odata),  64'd0);
    check_eq({tag, "_strobe"}, 64'(strobe), 64'd0);
    check_eq({tag, "_busy"},   64'(busy),   64'd1);
    check_eq({tag, "_ready"},  64'(ready),  64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (strobe) begin
      check_eq("strobe_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("comm", 64'(comm), 64'(e.comm));
        check_eq("data", 64'(odata), 64'(e.data));
        check_eq("gap", 64'(cyc - last_cyc), 64'(e.gap));
        $display("[TB] strobe cycle %0d comm=0x%03h data=0x%08h", cyc, comm, odata);
      end
      last_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    last_cyc = 0;
    rst_n    = 1'b1;
    update   = 1'b0;
    data     = 32'd0;
    col      = 7'd0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset("por");

    // Power-up wait and init sequence, with the exact IDLE-entry boundary.
    @(negedge clk);
    #1 rst_n = 1'b1;
    last_cyc = cyc;
    push_init(20);
    wait_size(0, 100, "init_drain");
    repeat (3) @(negedge clk);
    check_eq("pre_idle_busy",  64'(busy),  64'd1);
    check_eq("pre_idle_ready", 64'(ready), 64'd0);
    @(negedge clk);
    check_eq("idle_busy",  64'(busy),  64'd0);
    check_eq("idle_ready", 64'(ready), 64'd1);

    // Refresh from IDLE; i_data changes mid-CHAR must not leak into the frame.
    repeat (3) @(negedge clk);
    data = 32'h33323100;
    col  = 7'h40;
    push_frame(32'h33323100, 7'h40, 1);
    pulse_update(1'b1);
    wait_size(2, 100, "frame1_to_char");
    data = 32'hFFFFFFFF;
    wait_size(0, 100, "frame1_drain");
    repeat (6) @(negedge clk);
    check_eq("snapshot_held", 64'(odata), 64'h33323100);
    check_eq("frame1_busy",   64'(busy),  64'd0);

    col = 7'h05;
    push_frame(32'hFFFFFFFF, 7'h05, 1);
    pulse_update(1'b1);
    wait_size(0, 100, "frame2_drain");
    repeat (6) @(negedge clk);
    check_eq("snapshot_new", 64'(odata), 64'hFFFFFFFF);

    // Requests during PWR and INIT collapse into one refresh after init.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset("rst2");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    last_cyc = cyc;
    data = 32'h44434241;
    col  = 7'h00;
    push_init(20);
    push_frame(32'h44434241, 7'h00, 5);
    repeat (5) @(negedge clk);
    pulse_update(1'b0);
    repeat (20) @(negedge clk);
    pulse_update(1'b0);
    check_eq("init_busy",  64'(busy),  64'd1);
    check_eq("init_ready", 64'(ready), 64'd0);
    repeat (5) @(negedge clk);
    pulse_update(1'b0);
    wait_size(0, 200, "pending_drain");
    repeat (30) @(negedge clk);
    check_eq("pending_once_busy", 64'(busy), 64'd0);

    // Reset in CHAR n=1 with a refresh pending: full init, no refresh after.
    data = 32'h37363500;
    col  = 7'h7F;
    push_frame(32'h37363500, 7'h7F, 1);
    pulse_update(1'b1);
    wait_size(2, 100, "frame4_to_char");
    pulse_update(1'b0);
    wait_size(1, 100, "frame4_char1");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset("rst_char");
    sb.delete();
    repeat (3) @(negedge clk);
    #1 check_reset("rst_hold");
    rst_n = 1'b1;
    last_cyc = cyc;
    push_init(20);
    wait_size(0, 100, "reinit_drain");
    repeat (40) @(negedge clk);
    check_eq("reinit_busy",  64'(busy),  64'd0);
    check_eq("reinit_ready", 64'(ready), 64'd1);
    check_eq("reinit_data",  64'(odata), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
- Command source sitting directly upstream of the LCD `display` stage; drives its 11-bit command bus and character bank.
- After reset, waits out HD44780 power-up, then issues the 4-instruction init sequence.
- On each `i_update` request, snapshots the character bank and writes it to the LCD: one set-DDRAM-address instruction, then one data write per character.
- Paces every transfer by cycle-count timers (25 MHz clock); no busy-flag readback (RW always 0).

Parameters:
- SIZE, 4, number of byte slots in the character bank; multiple of 4; slot 0 is unused (index 0 of display selects the instruction path), so SIZE-1 characters are written.
- STEP_CYC, 1250, cycles each command is held (50 us at 25 MHz).
- PWR_CYC, 375000, power-up wait after reset (15 ms).
- CLR_CYC, 41000, hold after the clear-display instruction (1.64 ms).
- TW, 19, timer width; must hold max(PWR_CYC, CLR_CYC, STEP_CYC).

Ports:
- i_clk  in  1  system clock, 25 MHz
- i_rst_n  in  1  asynchronous active-low reset
- i_update  in  1  single-cycle request to rewrite the display
- i_data  in  SIZE*8  character bank, ASCII; byte k at [k*8+7:k*8]
- i_col  in  7  DDRAM start address for the write
- o_comm  out  11  command bus to display: [7:0] payload, [8] RW, [9] RS, [10] source select
- o_data  out  SIZE*8  snapshot of i_data, to display
- o_strobe  out  1  one-cycle pulse on the first cycle of each new o_comm value
- o_busy  out  1  high whenever not in IDLE
- o_ready  out  1  high once init has completed; sticky until reset

Behaviour:
- Reset (async, i_rst_n=0): o_comm=0, o_data=0, o_strobe=0, o_busy=1, o_ready=0, state=PWR, timer=0, pending=0.
- Command encodings:
  - Instruction: [10]=0, [9]=0, [8]=0, [7:0]=opcode.
  - Character write: [10]=1, [9]=1, [8]=0, [7:0]=n, where n=0..SIZE-2 selects bank byte n+1 in display.
- Every o_comm change occurs on a registered edge; o_strobe is high in that same cycle only.
- Timer counts from 0; a state advances on the cycle timer==LIMIT-1, and the timer clears on every state or step change.
- FSM:
  - PWR: o_comm=0, no strobe; wait PWR_CYC -> INIT, step 0.
  - INIT: steps 0..3 issue opcodes 0x38, 0x0C, 0x01, 0x06. Each is held STEP_CYC, except step 2 (clear), which is held CLR_CYC. After step 3 -> IDLE; o_ready=1.
  - IDLE: o_busy=0. On i_update or pending: latch o_data<=i_data and col<=i_col, clear pending -> ADDR.
  - ADDR: issue 0x80|col; hold STEP_CYC -> CHAR, n=0.
  - CHAR: issue character write n; hold STEP_CYC; n++; after n=SIZE-2 -> IDLE.
- i_update while busy (PWR, INIT, ADDR, CHAR): sets pending. It is never lost and never queues more than one; served on entry to IDLE, with a strobe on the next cycle.
- i_update and an IDLE entry in the same cycle: treat as pending; exactly one refresh follows.
- i_data is sampled only at refresh start; changes mid-write do not affect the frame in progress.
- Address arithmetic: col is 7 bits, OR'd into 0x80; no clamping; the LCD wraps.
- Reset mid-operation: immediate return to PWR; the full init reruns; pending is discarded.

Decomposition:
- Package lcd_pkg:
  - Opcodes LCD_FUNC_SET=8'h38, LCD_DISP_ON=8'h0C, LCD_CLEAR=8'h01, LCD_ENTRY=8'h06, LCD_SET_DDRAM=8'h80.
  - Command field bit positions (COMM_RW=8, COMM_RS=9, COMM_SEL=10).
  - State encoding (PWR, INIT, ADDR, CHAR, IDLE).
- One sub-module: lcd_delay_timer. TW-bit up-counter with synchronous clear and `o_done` at LIMIT-1; reused for all waits.

Test Plan:
Sim parameters for all tests: STEP_CYC=4, PWR_CYC=20, CLR_CYC=10.
- Reset release, i_update low: no strobe for 20 cycles; then strobes with o_comm=0x038, 0x00C, 0x001, 0x006 at spacing 4, 4, 10, 4; o_ready=1 and o_busy=0 on the cycle after the last hold.
- i_update pulse in IDLE with i_data=32'h33_32_31_00, i_col=7'h40: o_comm=0x0C0, then 0x600, 0x601, 0x602, each held 4 cycles; o_data=32'h33323100 throughout.
- i_update pulse during PWR, plus two more pulses during INIT: exactly one refresh after init, starting one cycle after IDLE entry.
- i_data changed to 32'hFFFFFFFF mid-CHAR: o_data keeps the old snapshot until the next refresh.
- i_rst_n pulsed low during CHAR n=1: all outputs return to reset values asynchronously; full init sequence repeats; no pending refresh afterwards.
